// File: rtl/hsv_mixer_pkg.sv
// Shared definitions for the HSV mixer pipeline: colour word layout and PWM constants.
package hsv_mixer_pkg;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  // Last PWM count before wrap; 255 steps per period.
  localparam logic [7:0] PWM_LAST = 8'd254;

  typedef logic [23:0] rgb24_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, compare against the shared counter, output flop.
module pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] duty,
  input  logic [7:0] cnt,
  input  logic       enable,
  output logic       pwm
);

  logic [7:0] active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 8'd0;
      pwm      <= 1'b0;
    end else begin
      if (load) begin
        active_q <= duty;
      end
      pwm <= enable && (cnt < active_q);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Drives R/G/B LED PWM pins from a 24-bit colour word; colour updates land on period boundaries.
module rgb_pwm_driver
  import hsv_mixer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           rgb_i,
  input  logic                  rgb_valid_i,
  output logic                  rgb_ready_o,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  enable_i,
  output logic                  pwm_r_o,
  output logic                  pwm_g_o,
  output logic                  pwm_b_o,
  output logic                  period_start_o
);

  rgb24_t                pending_q;
  logic                  pending_valid_q;
  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [7:0]            pwm_cnt_q;
  logic                  tick;
  logic                  boundary;
  logic                  accept;
  logic                  xfer;

  assign rgb_ready_o = !pending_valid_q;
  assign accept      = rgb_valid_i && rgb_ready_o;
  // >= lets a shrinking prescale take effect immediately instead of wrapping the counter.
  assign tick        = enable_i && (pre_cnt_q >= prescale_i);
  assign boundary    = tick && (pwm_cnt_q == PWM_LAST);
  // While disabled every cycle acts as a boundary for the buffer.
  assign xfer        = pending_valid_q && (boundary || !enable_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      pre_cnt_q       <= '0;
      pwm_cnt_q       <= 8'd0;
      period_start_o  <= 1'b0;
    end else begin
      if (accept) begin
        pending_q       <= rgb_i;
        pending_valid_q <= 1'b1;
      end else if (xfer) begin
        pending_valid_q <= 1'b0;
      end

      if (!enable_i || tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + 1'b1;
      end

      if (!enable_i || boundary) begin
        pwm_cnt_q <= 8'd0;
      end else if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end

      period_start_o <= boundary;
    end
  end

  pwm_channel u_chan_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (xfer),
    .duty   (pending_q[R_MSB:R_LSB]),
    .cnt    (pwm_cnt_q),
    .enable (enable_i),
    .pwm    (pwm_r_o)
  );

  pwm_channel u_chan_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (xfer),
    .duty   (pending_q[G_MSB:G_LSB]),
    .cnt    (pwm_cnt_q),
    .enable (enable_i),
    .pwm    (pwm_g_o)
  );

  pwm_channel u_chan_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (xfer),
    .duty   (pending_q[B_MSB:B_LSB]),
    .cnt    (pwm_cnt_q),
    .enable (enable_i),
    .pwm    (pwm_b_o)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: duty counts per period, buffering and boundary timing.
module tb_rgb_pwm_driver;

  logic        clk;
  logic        rst_n;
  logic [23:0] rgb_i;
  logic        rgb_valid_i;
  logic        rgb_ready_o;
  logic [7:0]  prescale_i;
  logic        enable_i;
  logic        pwm_r_o;
  logic        pwm_g_o;
  logic        pwm_b_o;
  logic        period_start_o;

  int n_cmp;
  int n_err;
  int m_r, m_g, m_b, m_ps;

  rgb_pwm_driver #(
    .PRESCALE_W (8)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rgb_i          (rgb_i),
    .rgb_valid_i    (rgb_valid_i),
    .rgb_ready_o    (rgb_ready_o),
    .prescale_i     (prescale_i),
    .enable_i       (enable_i),
    .pwm_r_o        (pwm_r_o),
    .pwm_g_o        (pwm_g_o),
    .pwm_b_o        (pwm_b_o),
    .period_start_o (period_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count high cycles of each output over n negedges.
  task automatic measure(input int n);
    m_r = 0; m_g = 0; m_b = 0; m_ps = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_r  += int'(pwm_r_o);
      m_g  += int'(pwm_g_o);
      m_b  += int'(pwm_b_o);
      m_ps += int'(period_start_o);
    end
  endtask

  task automatic wait_ps(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (period_start_o) return;
    end
    check(tag, 0, 1);
  endtask

  task automatic push(input string tag, input logic [23:0] w);
    for (int i = 0; i < 3000 && !rgb_ready_o; i++) @(negedge clk);
    if (!rgb_ready_o) check(tag, 0, 1);
    rgb_i       = w;
    rgb_valid_i = 1'b1;
    @(negedge clk);
    rgb_valid_i = 1'b0;
  endtask

  task automatic check_period(input string tag, input int n, input int r, input int g,
                              input int b);
    measure(n);
    check({tag, "_r"}, m_r, r);
    check({tag, "_g"}, m_g, g);
    check({tag, "_b"}, m_b, b);
    check({tag, "_ps"}, m_ps, 1);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst_n       = 1'b0;
    rgb_i       = '0;
    rgb_valid_i = 1'b0;
    prescale_i  = 8'd0;
    enable_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", rgb_ready_o, 1);
    check("rst_pwm", {pwm_r_o, pwm_g_o, pwm_b_o}, 0);
    check("rst_ps", period_start_o, 0);
    rst_n = 1'b1;

    // Full / half / zero duty with prescale 0.
    enable_i = 1'b1;
    push("t2_push", 24'hFF8000);
    wait_ps("t2_wait", 600);
    check_period("t2", 255, 255, 128, 0);

    // Back-to-back pushes: B stalls until A is applied at boundary 1.
    push("t3_pushA", 24'h101010);
    check("t3_ready_low", rgb_ready_o, 0);
    rgb_i       = 24'h202020;
    rgb_valid_i = 1'b1;
    n = 0;
    while (n < 600 && !rgb_ready_o) begin
      @(negedge clk);
      n++;
    end
    check("t3_ready_at_ps", period_start_o, 1);
    @(posedge clk);
    #1 rgb_valid_i = 1'b0;
    check_period("t3_A", 255, 16, 16, 16);
    wait_ps("t3_wait", 600);
    check_period("t3_B", 255, 32, 32, 32);

    // Prescale 3: 1020-clock period, minimum duty is 4 clocks.
    prescale_i = 8'd3;
    push("t4_push", 24'h010000);
    wait_ps("t4_wait", 3000);
    check_period("t4", 1020, 4, 0, 0);

    // Disabled: outputs off, pending transfers immediately.
    enable_i   = 1'b0;
    prescale_i = 8'd1;
    push("t5_push", 24'h00FF00);
    check("t5_ready_full", rgb_ready_o, 0);
    @(negedge clk);
    check("t5_ready_empty", rgb_ready_o, 1);
    measure(20);
    check("t5_off_pwm", m_r + m_g + m_b, 0);
    check("t5_off_ps", m_ps, 0);
    enable_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 2000 && !period_start_o);
    check("t5_first_ps", n, 510);
    check_period("t5", 510, 0, 510, 0);

    // Word accepted in the boundary cycle is deferred one full period.
    check("t6_at_ps", period_start_o, 1);
    prescale_i = 8'd0;
    repeat (254) @(negedge clk);
    check("t6_ready", rgb_ready_o, 1);
    rgb_i       = 24'h0000FF;
    rgb_valid_i = 1'b1;
    @(negedge clk);
    rgb_valid_i = 1'b0;
    check("t6_boundary", period_start_o, 1);
    check_period("t6_old", 255, 0, 255, 0);
    check_period("t6_new", 255, 0, 0, 255);

    // Asynchronous reset mid-period with pending full discards the word.
    push("t1_push", 24'hFFFFFF);
    repeat (3) @(negedge clk);
    check("t1_b_high", pwm_b_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_pwm", {pwm_r_o, pwm_g_o, pwm_b_o}, 0);
    check("t1_rst_ready", rgb_ready_o, 1);
    check("t1_rst_ps", period_start_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps("t1_wait", 600);
    check_period("t1_after", 255, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
